// File: rtl/run_seq_ctrl_if.sv
// Handshake bundle for run_seq_ctrl: word input channel and count output channel.
// master drives words and accepts counts; slave is the sequencer side.
interface run_seq_ctrl_if #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_word;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_count
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_count
  );
endinterface

// File: rtl/run_seq_ctrl.sv
// Run sequencer: takes a word over valid/ready, scans it MSB-first one bit per
// clock through a consecutive-equal-bit run detector, and returns the number of
// matches over a second valid/ready handshake.
// Optional build macro RUN_SEQ_CARRY_RUN_EN: when defined, the run state carries
// across word boundaries and is cleared only by reset.
module run_seq_ctrl #(
  parameter int unsigned WORD_W  = 8,
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic          clock,
  input  logic          reset,
  run_seq_ctrl_if.slave bus,
  output logic          match,
  output logic          busy
);

  localparam int unsigned IdxW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned RunW = $clog2(RUN_LEN + 1);
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(WORD_W - 1);
  localparam logic [RunW-1:0]  RunMax  = RunW'(RUN_LEN);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [1:0] {StIdle, StShift, StReport} state_e;

  state_e            state_q;
  logic [WORD_W-1:0] shreg_q;
  logic [IdxW-1:0]   idx_q;
  logic              run_bit_q, run_bit_d;
  logic [RunW-1:0]   run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [CNT_W-1:0]  out_count_q;
  logic              match_q;
  logic              busy_q;
  logic              cur_bit;
  logic              hit;

  // Run detector update for the bit currently at the shift-register MSB.
  always_comb begin
    cur_bit   = shreg_q[WORD_W-1];
    run_bit_d = cur_bit;
    if (run_cnt_q == '0 || cur_bit != run_bit_q) begin
      run_cnt_d = RunW'(1);
    end else if (run_cnt_q == RunMax) begin
      // Saturate so every further equal bit keeps matching (overlapping runs).
      run_cnt_d = RunMax;
    end else begin
      run_cnt_d = run_cnt_q + 1'b1;
    end
    hit     = (run_cnt_d == RunMax);
    count_d = (hit && count_q != CntMax) ? count_q + 1'b1 : count_q;
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      idx_q       <= '0;
      run_bit_q   <= 1'b0;
      run_cnt_q   <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      match_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          match_q <= 1'b0;
          if (bus.in_valid && in_ready_q) begin
            shreg_q    <= bus.in_word;
            idx_q      <= '0;
            count_q    <= '0;
`ifdef RUN_SEQ_CARRY_RUN_EN
            // Run state deliberately kept so runs span word boundaries.
`else
            run_bit_q  <= 1'b0;
            run_cnt_q  <= '0;
`endif
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StShift;
          end
        end
        StShift: begin
          shreg_q   <= shreg_q << 1;
          run_bit_q <= run_bit_d;
          run_cnt_q <= run_cnt_d;
          count_q   <= count_d;
          match_q   <= hit;
          idx_q     <= idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            out_valid_q <= 1'b1;
            out_count_q <= count_d;
            state_q     <= StReport;
          end
        end
        StReport: begin
          match_q <= 1'b0;
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_count = out_count_q;
  assign match         = match_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_run_seq_ctrl.sv
// Testbench for run_seq_ctrl: directed cases from the block's behaviour plus random
// words, checked against a bit-history reference model.
module tb_run_seq_ctrl;

  localparam int unsigned WordW  = 8;
  localparam int unsigned RunLen = 4;
  localparam int unsigned CntW   = 4;
`ifdef RUN_SEQ_CARRY_RUN_EN
  localparam bit Carry = 1'b1;
`else
  localparam bit Carry = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic match;
  logic busy;

  run_seq_ctrl_if #(.WORD_W(WordW), .CNT_W(CntW)) bus ();

  run_seq_ctrl #(
    .WORD_W (WordW),
    .RUN_LEN(RunLen),
    .CNT_W  (CntW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus),
    .match(match),
    .busy (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Stream of bits seen by the detector since the run state was last cleared.
  bit hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
  endtask

  // A bit matches when it and the RUN_LEN-1 bits before it in the stream are equal.
  function automatic bit model_bit(input bit b);
    hist.push_back(b);
    if (hist.size() > RunLen) void'(hist.pop_front());
    if (hist.size() < RunLen) return 1'b0;
    foreach (hist[i]) if (hist[i] != b) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_word   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_count", 32'(bus.out_count), 32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    hist.delete();
  endtask

  // Send one word, hold out_ready low for `stall` extra REPORT cycles, return the count.
  task automatic send_word(input logic [WordW-1:0] w, input int stall, output int got);
    bit exp_m[WordW];
    int exp_cnt = 0;
    if (!Carry) hist.delete();
    for (int k = 0; k < int'(WordW); k++) begin
      exp_m[k] = model_bit(w[WordW-1-k]);
      if (exp_m[k] && exp_cnt < (1 << CntW) - 1) exp_cnt++;
    end
    @(negedge clock);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_word   = w;
    bus.out_ready = 1'b0;
    @(negedge clock);
    check("shift_in_ready", 32'(bus.in_ready), 32'd0);
    check("shift_busy", 32'(busy), 32'd1);
    for (int k = 0; k < int'(WordW); k++) begin
      bus.in_valid = 1'($urandom);
      bus.in_word  = WordW'($urandom);
      @(negedge clock);
      check("match", 32'(match), 32'(exp_m[k]));
      check("out_valid_timing", 32'(bus.out_valid), 32'(k == int'(WordW) - 1));
      check("busy", 32'(busy), 32'd1);
    end
    check("out_count", 32'(bus.out_count), 32'(exp_cnt));
    bus.out_ready = (stall == 0);
    for (int s = 1; s <= stall; s++) begin
      bus.in_valid = 1'b1;
      @(negedge clock);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_out_count", 32'(bus.out_count), 32'(exp_cnt));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_match", 32'(match), 32'd0);
      if (s == stall) bus.out_ready = 1'b1;
    end
    got = int'(bus.out_count);
    @(negedge clock);
    check("post_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
    check("post_match", 32'(match), 32'd0);
    check("post_out_count", 32'(bus.out_count), 32'(exp_cnt));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int got;
    do_reset();
    send_word(8'h0F, 0, got);
    check("dir_0F", 32'(got), 32'd2);
    do_reset();
    send_word(8'hFF, 0, got);
    check("dir_FF", 32'(got), 32'd5);
    do_reset();
    send_word(8'hAA, 0, got);
    check("dir_AA", 32'(got), 32'd0);
    do_reset();
    send_word(8'h87, 0, got);
    check("dir_87", 32'(got), 32'd1);
    do_reset();
    send_word(8'h0F, 10, got);
    check("dir_0F_stall", 32'(got), 32'd2);

    do_reset();
    send_word(8'h0F, 0, got);
    check("pair_0F", 32'(got), 32'd2);
    send_word(8'hC0, 0, got);
    check("pair_C0", 32'(got), Carry ? 32'd5 : 32'd3);

    // Reset in the 4th SHIFT cycle of 8'hFF, after a nonzero count was reported.
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_word  = 8'hFF;
    @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_count", 32'(bus.out_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_match", 32'(match), 32'd0);
    reset = 1'b0;
    hist.delete();
    send_word(8'h0F, 0, got);
    check("after_rst_0F", 32'(got), 32'd2);

    for (int i = 0; i < 40; i++) begin
      send_word(WordW'($urandom), int'($urandom_range(0, 3)), got);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
